// File: rtl/mcu_pkg.sv
// ============================================================================
//  Module      : mcu_pkg
//  Description : Opcodes, sequencer state type and instruction-width helper
//                shared by the mcu_core_p design files.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_ANDI = 4'd4;
    localparam logic [3:0] OP_ORI  = 4'd5;
    localparam logic [3:0] OP_XORI = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [3:0] OP_ADD  = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_JZ   = 4'd12;
    localparam logic [3:0] OP_JC   = 4'd13;
    localparam logic [3:0] OP_OUT  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } mcu_state_t;

    // Instruction word = 4-bit opcode above a DATA_W-bit immediate.
    function automatic int calc_iw(input int data_w);
        return data_w + 4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_alu.sv
// ============================================================================
//  Module      : mcu_alu
//  Description : Combinational ALU: result, Z/C flags and accumulator-write
//                decode for one opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_alu
    import mcu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              c_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o,
    output logic              acc_we_o
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, acc_i} + {1'b0, operand_i};
    // The extra top bit of the difference is the unsigned borrow.
    assign w_diff = {1'b0, acc_i} - {1'b0, operand_i};

    always_comb begin
        result_o = acc_i;
        c_o      = c_i;
        acc_we_o = 1'b0;
        case (op_i)
            OP_LDI, OP_LD: begin
                result_o = operand_i;
                acc_we_o = 1'b1;
            end
            OP_ADDI, OP_ADD: begin
                result_o = w_sum[DATA_W-1:0];
                c_o      = w_sum[DATA_W];
                acc_we_o = 1'b1;
            end
            OP_SUBI, OP_SUB: begin
                result_o = w_diff[DATA_W-1:0];
                c_o      = w_diff[DATA_W];
                acc_we_o = 1'b1;
            end
            OP_ANDI: begin
                result_o = acc_i & operand_i;
                c_o      = 1'b0;
                acc_we_o = 1'b1;
            end
            OP_ORI: begin
                result_o = acc_i | operand_i;
                c_o      = 1'b0;
                acc_we_o = 1'b1;
            end
            OP_XORI: begin
                result_o = acc_i ^ operand_i;
                c_o      = 1'b0;
                acc_we_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign z_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/mcu_core_p.sv
// ============================================================================
//  Module      : mcu_core_p
//  Description : Parametrised three-cycle Harvard microcontroller with a
//                streaming program loader, HALT and a strobed output port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_core_p
    import mcu_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  PMEM_DEPTH = 256,
    parameter int  DMEM_DEPTH = 16,
    localparam int PC_W       = $clog2(PMEM_DEPTH),
    localparam int DA_W       = $clog2(DMEM_DEPTH),
    localparam int IW         = calc_iw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [IW-1:0]     ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [PC_W-1:0]   pc
);

    if (PC_W > DATA_W) begin : g_bad_params
        $error("mcu_core_p: PMEM_DEPTH needs more address bits than DATA_W");
    end

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(PMEM_DEPTH - 1);

    logic [IW-1:0]     pmem [PMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    mcu_state_t        state_q, state_d;
    logic [PC_W-1:0]   ld_addr_q, ld_addr_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ld_ready_q;
    logic              halted_q;
    logic [IW-1:0]     ir_q;
    logic [DATA_W-1:0] dr_q;

    logic              pmem_we;
    logic              dmem_we;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_imm;
    logic [DA_W-1:0]   w_daddr;
    logic [PC_W-1:0]   w_pc_inc;
    logic [DATA_W-1:0] w_operand;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_z;
    logic              w_alu_c;
    logic              w_alu_we;

    assign w_op     = ir_q[IW-1:DATA_W];
    assign w_imm    = ir_q[DATA_W-1:0];
    assign w_daddr  = w_imm[DA_W-1:0];
    assign w_pc_inc = (pc_q == LAST_ADDR) ? '0 : pc_q + PC_W'(1);
    assign w_operand = (w_op == OP_LD || w_op == OP_ADD || w_op == OP_SUB) ? dr_q : w_imm;

    mcu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i      (w_op),
        .acc_i     (acc_q),
        .operand_i (w_operand),
        .c_i       (c_q),
        .result_o  (w_alu_result),
        .z_o       (w_alu_z),
        .c_o       (w_alu_c),
        .acc_we_o  (w_alu_we)
    );

    always_comb begin
        state_d     = state_q;
        ld_addr_d   = ld_addr_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        pmem_we     = 1'b0;
        dmem_we     = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    pmem_we   = 1'b1;
                    ld_addr_d = ld_addr_q + PC_W'(1);
                    if (ld_last || ld_addr_q == LAST_ADDR) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                        acc_d   = '0;
                        z_d     = 1'b0;
                        c_d     = 1'b0;
                    end
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = w_pc_inc;
                if (w_alu_we) begin
                    acc_d = w_alu_result;
                    z_d   = w_alu_z;
                    c_d   = w_alu_c;
                end
                case (w_op)
                    OP_JMP: pc_d = w_imm[PC_W-1:0];
                    OP_JZ:  if (z_q) pc_d = w_imm[PC_W-1:0];
                    OP_JC:  if (c_q) pc_d = w_imm[PC_W-1:0];
                    OP_ST:  dmem_we = 1'b1;
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            ld_addr_q   <= '0;
            pc_q        <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ld_ready_q  <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ld_ready_q  <= (state_d == ST_LOAD);
            halted_q    <= (state_d == ST_HALT);
        end
    end

    // Memories are never reset; a reset cycle only suppresses writes.
    always_ff @(posedge clk) begin
        if (pmem_we && !rst) pmem[ld_addr_q] <= ld_data;
        if (dmem_we && !rst) dmem[w_daddr] <= acc_q;
        if (state_q == ST_FETCH)  ir_q <= pmem[pc_q];
        if (state_q == ST_DECODE) dr_q <= dmem[w_daddr];
    end

    assign ld_ready  = ld_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc        = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_mcu_core_p.sv
// ============================================================================
//  Module      : tb_mcu_core_p
//  Description : Directed and random programs for mcu_core_p compared against
//                an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_core_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_last, ld_ready, out_valid, halted;
    logic [11:0] ld_data;
    logic [7:0]  out_data;
    logic [7:0]  pc;

    logic        ld_valid2, ld_last2, ld_ready2, out_valid2, halted2;
    logic [15:0] ld_data2;
    logic [11:0] out_data2;
    logic [3:0]  pc2;

    int n_vec = 0;
    int n_err = 0;

    // Architectural state of the reference model.
    logic [11:0] m_prog [256];
    int          m_dmem [16];
    int          m_acc, m_z, m_c, m_pc, m_out, m_outv, m_halt;

    always #5 clk = ~clk;

    mcu_core_p u_dut (
        .clk (clk), .rst (rst),
        .ld_valid (ld_valid), .ld_data (ld_data), .ld_last (ld_last), .ld_ready (ld_ready),
        .out_data (out_data), .out_valid (out_valid), .halted (halted), .pc (pc)
    );

    mcu_core_p #(.DATA_W(12), .PMEM_DEPTH(16), .DMEM_DEPTH(16)) u_dut2 (
        .clk (clk), .rst (rst),
        .ld_valid (ld_valid2), .ld_data (ld_data2), .ld_last (ld_last2), .ld_ready (ld_ready2),
        .out_data (out_data2), .out_valid (out_valid2), .halted (halted2), .pc (pc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int a, input int op, input int imm);
        logic [3:0] o;
        logic [7:0] i;
        o = op[3:0];
        i = imm[7:0];
        m_prog[a] = {o, i};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_pc", pc, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        m_out = 0;
    endtask

    task automatic load_prog(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    ld_valid = 1'b0;
                    tick();
                end
            end
            chk("ld_ready_high", ld_ready, 1);
            ld_valid = 1'b1;
            ld_data  = m_prog[i];
            ld_last  = (i == n - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ld_ready_drop", ld_ready, 0);
        chk("pc_after_load", pc, 0);
        m_acc = 0; m_z = 0; m_c = 0; m_pc = 0; m_halt = 0; m_outv = 0;
    endtask

    // One instruction at the ISA level, written from the opcode semantics.
    task automatic model_step();
        int op, imm, a, nxt, t;
        op   = int'(m_prog[m_pc][11:8]);
        imm  = int'(m_prog[m_pc][7:0]);
        a    = imm % 16;
        nxt  = (m_pc + 1) % 256;
        m_outv = 0;
        case (op)
            1:  begin m_acc = imm; m_z = (m_acc == 0); end
            2:  begin t = m_acc + imm; m_c = (t > 255); m_acc = t % 256; m_z = (m_acc == 0); end
            3:  begin m_c = (m_acc < imm); m_acc = (m_acc - imm + 256) % 256; m_z = (m_acc == 0); end
            4:  begin m_acc = m_acc & imm; m_c = 0; m_z = (m_acc == 0); end
            5:  begin m_acc = m_acc | imm; m_c = 0; m_z = (m_acc == 0); end
            6:  begin m_acc = m_acc ^ imm; m_c = 0; m_z = (m_acc == 0); end
            7:  begin m_acc = m_dmem[a]; m_z = (m_acc == 0); end
            8:  m_dmem[a] = m_acc;
            9:  begin t = m_acc + m_dmem[a]; m_c = (t > 255); m_acc = t % 256; m_z = (m_acc == 0); end
            10: begin m_c = (m_acc < m_dmem[a]); m_acc = (m_acc - m_dmem[a] + 256) % 256; m_z = (m_acc == 0); end
            11: nxt = imm;
            12: if (m_z != 0) nxt = imm;
            13: if (m_c != 0) nxt = imm;
            14: begin m_out = m_acc; m_outv = 1; end
            15: begin m_halt = 1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic run_instr(input int max_instr);
        for (int k = 0; k < max_instr && m_halt == 0; k++) begin
            model_step();
            repeat (3) @(posedge clk);
            #1;
            if (m_halt == 0) chk("pc", pc, m_pc);
            chk("out_valid", out_valid, m_outv);
            chk("out_data", out_data, m_out);
            chk("halted", halted, m_halt);
        end
        if (m_halt != 0) begin
            repeat (3) tick();
            chk("halt_held", halted, 1);
            chk("halt_no_strobe", out_valid, 0);
            chk("halt_ld_ready", ld_ready, 0);
        end
    endtask

    initial begin
        int e;
        rst = 1'b1;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        ld_valid2 = 1'b0; ld_last2 = 1'b0; ld_data2 = '0;
        for (int i = 0; i < 256; i++) m_prog[i] = '0;
        tick();
        tick();
        chk("rst2_ld_ready", ld_ready2, 1);
        chk("rst2_pc", pc2, 0);
        rst = 1'b0;

        // 12-bit core, 16-word PMEM: fill without ld_last, then wrap the PC.
        for (int i = 0; i < 16; i++) begin
            chk("ld2_ready_high", ld_ready2, 1);
            ld_valid2 = 1'b1;
            ld_data2  = (i == 0) ? {4'd11, 12'hFF3} : 16'h0000;
            tick();
        end
        ld_valid2 = 1'b0;
        chk("ld2_ready_drop", ld_ready2, 0);
        chk("ld2_pc", pc2, 0);
        e = 0;
        for (int k = 0; k < 20; k++) begin
            e = (e == 0) ? 3 : (e + 1) % 16;
            repeat (3) @(posedge clk);
            #1;
            chk("pc2_wrap", pc2, e);
        end

        // Seed every DMEM word with a known value.
        do_reset();
        for (int a = 0; a < 16; a++) begin
            set_w(2 * a, 1, $urandom_range(0, 255));
            set_w(2 * a + 1, 8, a);
        end
        set_w(32, 15, 0);
        load_prog(33, 1'b1);
        run_instr(100);

        // Carry out of ADDI observed through JZ/JC.
        do_reset();
        set_w(0, 1, 8'hF0); set_w(1, 2, 8'h20); set_w(2, 12, 7); set_w(3, 13, 5);
        set_w(4, 0, 0);     set_w(5, 14, 0);    set_w(6, 15, 0); set_w(7, 15, 0);
        load_prog(8, 1'b0);
        run_instr(20);
        chk("arith_out", out_data, 8'h10);
        chk("arith_halted", halted, 1);

        // Store/load forwarding and SUBI borrow; the reset also leaves HALT.
        do_reset();
        set_w(0, 1, 5); set_w(1, 8, 3); set_w(2, 1, 9); set_w(3, 7, 3); set_w(4, 3, 6);
        set_w(5, 13, 7); set_w(6, 15, 0); set_w(7, 14, 0); set_w(8, 15, 0);
        load_prog(9, 1'b0);
        run_instr(20);
        chk("borrow_out", out_data, 8'hFF);

        // DMEM aliasing, JZ taken/not-taken, JMP to the top word.
        do_reset();
        for (int i = 0; i < 256; i++) m_prog[i] = '0;
        set_w(0, 1, 8'h2A); set_w(1, 8, 8'h13); set_w(2, 1, 0);  set_w(3, 7, 8'h03);
        set_w(4, 14, 0);    set_w(5, 3, 8'h2A); set_w(6, 12, 8); set_w(7, 15, 0);
        set_w(8, 2, 1);     set_w(9, 12, 7);    set_w(10, 11, 8'hFF);
        set_w(255, 15, 0);
        load_prog(256, 1'b0);
        run_instr(40);
        chk("alias_out", out_data, 8'h2A);

        // Random programs over the full PMEM, no HALT.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) set_w(i, $urandom_range(0, 14), $urandom_range(0, 255));
            load_prog(256, 1'b1);
            run_instr(300);
        end

        // Reset during the EXECUTE cycle of an ADD.
        do_reset();
        set_w(0, 1, 3); set_w(1, 14, 0); set_w(2, 9, 4); set_w(3, 15, 0);
        load_prog(4, 1'b0);
        run_instr(2);
        chk("pre_rst_out", out_data, 3);
        tick();
        tick();
        do_reset();
        tick();
        chk("post_rst_pc_idle", pc, 0);
        chk("post_rst_ld_ready", ld_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
